// File: rtl/global_buffer_param.sv
// rtl/global_buffer_param.sv - global buffer sizing parameters
package global_buffer_param;
  localparam int BANK_ADDR_WIDTH     = 17;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int CGRA_CFG_DATA_WIDTH = 32;
  localparam int SRAM_LATENCY        = 2;
endpackage

// File: rtl/global_buffer_pkg.sv
// rtl/global_buffer_pkg.sv - global buffer shared types
package global_buffer_pkg;
  typedef enum logic [1:0] {
    SRAM_CFG_IDLE,
    SRAM_CFG_WR_ISSUE,
    SRAM_CFG_RD_ISSUE,
    SRAM_CFG_RD_WAIT
  } sram_cfg_state_t;
endpackage

// File: rtl/glb_bank_sram_cfg_ctrl.sv
// rtl/glb_bank_sram_cfg_ctrl.sv - per-bank config port: 32-bit config accesses onto the 64-bit bank SRAM port
import global_buffer_pkg::*;

module glb_bank_sram_cfg_ctrl #(
  parameter int BANK_ADDR_WIDTH     = global_buffer_param::BANK_ADDR_WIDTH,
  parameter int CGRA_CFG_DATA_WIDTH = global_buffer_param::CGRA_CFG_DATA_WIDTH,
  parameter int BANK_DATA_WIDTH     = global_buffer_param::BANK_DATA_WIDTH,
  parameter int SRAM_LATENCY        = global_buffer_param::SRAM_LATENCY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cfg_wr_en,
  input  logic [BANK_ADDR_WIDTH-1:0]     cfg_wr_addr,
  input  logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_wr_data,
  input  logic                           cfg_rd_en,
  input  logic [BANK_ADDR_WIDTH-1:0]     cfg_rd_addr,
  output logic [CGRA_CFG_DATA_WIDTH-1:0] cfg_rd_data,
  output logic                           cfg_rd_data_valid,
  output logic                           cfg_err,
  output logic                           mem_req,
  input  logic                           mem_gnt,
  output logic                           mem_wr_en,
  output logic [BANK_ADDR_WIDTH-4:0]     mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]     mem_wr_data,
  output logic [BANK_DATA_WIDTH/8-1:0]   mem_wr_strb,
  input  logic [BANK_DATA_WIDTH-1:0]     mem_rd_data
);

  localparam int STRB_WIDTH = BANK_DATA_WIDTH / 8;
  localparam int HALF_STRB  = STRB_WIDTH / 2;
  localparam int CNT_W      = $clog2(SRAM_LATENCY + 1);

  sram_cfg_state_t state, state_next;

  logic                           wr_pend;
  logic [BANK_ADDR_WIDTH-1:2]     wr_addr_q;
  logic [CGRA_CFG_DATA_WIDTH-1:0] wr_data_q;
  logic                           rd_pend;
  logic [BANK_ADDR_WIDTH-1:2]     rd_addr_q;
  logic                           half_sel;
  logic [CNT_W-1:0]               lat_cnt;

  logic wr_issue, rd_issue, wr_accept, rd_accept, rd_sample;
  logic unused_addr_lsbs;

  // Byte offset within the 32-bit config word carries no information.
  assign unused_addr_lsbs = ^{cfg_wr_addr[1:0], cfg_rd_addr[1:0]};

  assign wr_issue  = (state == SRAM_CFG_WR_ISSUE) && mem_gnt;
  assign rd_issue  = (state == SRAM_CFG_RD_ISSUE) && mem_gnt;
  // A slot freed by this cycle's grant can take a new request immediately.
  assign wr_accept = cfg_wr_en && (!wr_pend || wr_issue);
  assign rd_accept = cfg_rd_en && (!rd_pend || rd_issue);
  assign rd_sample = (state == SRAM_CFG_RD_WAIT) && (lat_cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      cfg_err   <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= cfg_wr_addr[BANK_ADDR_WIDTH-1:2];
        wr_data_q <= cfg_wr_data;
      end else if (wr_issue) begin
        wr_pend <= 1'b0;
      end
      if (rd_accept) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= cfg_rd_addr[BANK_ADDR_WIDTH-1:2];
      end else if (rd_issue) begin
        rd_pend <= 1'b0;
      end
      if ((cfg_wr_en && !wr_accept) || (cfg_rd_en && !rd_accept)) begin
        cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= SRAM_CFG_IDLE;
      half_sel          <= 1'b0;
      lat_cnt           <= '0;
      cfg_rd_data       <= '0;
      cfg_rd_data_valid <= 1'b0;
    end else begin
      state             <= state_next;
      cfg_rd_data_valid <= rd_sample;
      if (rd_issue) begin
        half_sel <= rd_addr_q[2];
        lat_cnt  <= CNT_W'(SRAM_LATENCY);
      end else if ((state == SRAM_CFG_RD_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
      if (rd_sample) begin
        cfg_rd_data <= half_sel ? mem_rd_data[BANK_DATA_WIDTH-1:BANK_DATA_WIDTH/2]
                                : mem_rd_data[BANK_DATA_WIDTH/2-1:0];
      end
    end
  end

  // Incoming requests are looked at directly so an idle bank issues on the next cycle.
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_strb = '0;
    case (state)
      SRAM_CFG_IDLE: begin
        if (wr_pend || cfg_wr_en) begin
          state_next = SRAM_CFG_WR_ISSUE;
        end else if (rd_pend || cfg_rd_en) begin
          state_next = SRAM_CFG_RD_ISSUE;
        end
      end
      SRAM_CFG_WR_ISSUE: begin
        mem_req     = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = wr_addr_q[BANK_ADDR_WIDTH-1:3];
        mem_wr_data = {wr_data_q, wr_data_q};
        mem_wr_strb = wr_addr_q[2] ? {{HALF_STRB{1'b1}}, {HALF_STRB{1'b0}}}
                                   : {{HALF_STRB{1'b0}}, {HALF_STRB{1'b1}}};
        if (mem_gnt) begin
          state_next = (rd_pend || cfg_rd_en) ? SRAM_CFG_RD_ISSUE : SRAM_CFG_IDLE;
        end
      end
      SRAM_CFG_RD_ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_q[BANK_ADDR_WIDTH-1:3];
        if (mem_gnt) begin
          state_next = SRAM_CFG_RD_WAIT;
        end
      end
      SRAM_CFG_RD_WAIT: begin
        if (rd_sample) begin
          state_next = SRAM_CFG_IDLE;
        end
      end
      default: state_next = SRAM_CFG_IDLE;
    endcase
  end

endmodule

// File: tb/tb_glb_bank_sram_cfg_ctrl.sv
// tb/tb_glb_bank_sram_cfg_ctrl.sv - self-checking bench for glb_bank_sram_cfg_ctrl
module tb_glb_bank_sram_cfg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_wr_en;
  logic [16:0] cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_rd_en;
  logic [16:0] cfg_rd_addr;
  logic [31:0] cfg_rd_data;
  logic        cfg_rd_data_valid;
  logic        cfg_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wr_en;
  logic [13:0] mem_addr;
  logic [63:0] mem_wr_data;
  logic [7:0]  mem_wr_strb;
  logic [63:0] mem_rd_data;

  int n_checks = 0;
  int n_fail = 0;
  int valid_count = 0;

  // Reference: flat store of 32-bit config words indexed by byte address / 4.
  logic [31:0] ref_mem [0:32767];

  // Bank SRAM environment: byte-strobed 64-bit words, two-cycle read pipe.
  logic [63:0] sram [0:16383];
  logic        sram_init = 1'b0;
  logic [63:0] rd_pipe;
  logic        pl_en;
  logic [13:0] pl_addr;
  logic [63:0] pl_data;

  glb_bank_sram_cfg_ctrl dut (
    .clk(clk), .reset(reset),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_rd_en(cfg_rd_en), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid), .cfg_err(cfg_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 16384; i++) sram[i] <= '0;
      sram_init <= 1'b1;
    end else if (pl_en) begin
      sram[pl_addr] <= pl_data;
    end else if (mem_req && mem_gnt) begin
      if (mem_wr_en) begin
        for (int b = 0; b < 8; b++)
          if (mem_wr_strb[b]) sram[mem_addr][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
      end else begin
        rd_pipe <= sram[mem_addr];
      end
    end
    mem_rd_data <= rd_pipe;
  end

  always @(negedge clk) if (cfg_rd_data_valid === 1'b1) valid_count <= valid_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic preload(input logic [13:0] w, input logic [63:0] d);
    pl_en = 1'b1; pl_addr = w; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[{w, 1'b0}] = d[31:0];
    ref_mem[{w, 1'b1}] = d[63:32];
  endtask

  // Issues one read and waits for its return; cyc = -1 on timeout.
  task automatic do_read(input logic [16:0] a, input int budget, output int cyc, output logic [31:0] d);
    cfg_rd_en = 1'b1;
    cfg_rd_addr = a;
    cyc = -1;
    d = '0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      cfg_rd_en = 1'b0;
      sample();
      if (cfg_rd_data_valid === 1'b1) begin
        cyc = c;
        d = cfg_rd_data;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    sample();
    n_checks++;
    if ({cfg_rd_data, cfg_rd_data_valid, cfg_err, mem_req, mem_wr_en, mem_addr, mem_wr_data, mem_wr_strb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rd_data=%h valid=%b err=%b req=%b wr_en=%b addr=%h wdata=%h strb=%h want all zero",
               cfg_rd_data, cfg_rd_data_valid, cfg_err, mem_req, mem_wr_en, mem_addr, mem_wr_data, mem_wr_strb);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    int v0;
    preload(14'h2, 64'h12345678_9ABCDEF0);
    mem_gnt = 1'b1;
    v0 = valid_count;
    cfg_rd_en = 1'b1;
    cfg_rd_addr = 17'h00014;
    for (int c = 1; c <= 6; c++) begin
      tick();
      cfg_rd_en = 1'b0;
      sample();
      if (c == 1) begin
        n_checks++;
        if ({mem_req, mem_wr_en, mem_addr, mem_wr_strb} !== {1'b1, 1'b0, 14'h2, 8'h00}) begin
          n_fail++;
          $display("FAIL read_issue: got req=%b wr_en=%b addr=%h strb=%h want 1 0 0002 00", mem_req, mem_wr_en, mem_addr, mem_wr_strb);
        end
      end
      n_checks++;
      if (cfg_rd_data_valid !== (c == 4)) begin
        n_fail++;
        $display("FAIL read_valid_timing: cycle %0d got valid=%b want %b", c, cfg_rd_data_valid, (c == 4));
      end
      if (c >= 4) begin
        n_checks++;
        if (cfg_rd_data !== ref_mem[15'h5]) begin
          n_fail++;
          $display("FAIL read_data: cycle %0d got %h want %h", c, cfg_rd_data, ref_mem[15'h5]);
        end
      end
    end
    tick();
    n_checks++;
    if (valid_count - v0 !== 1) begin
      n_fail++;
      $display("FAIL read_pulse_count: got %0d want 1", valid_count - v0);
    end
  endtask

  task automatic test_write();
    logic [31:0] d;
    int cyc;
    logic [16:0] a_list [2];
    logic [31:0] d_list [2];
    a_list[0] = 17'h00010; d_list[0] = 32'hDEADBEEF;
    a_list[1] = 17'h0001C; d_list[1] = 32'hCAFEF00D;
    mem_gnt = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cfg_wr_en = 1'b1;
      cfg_wr_addr = a_list[k];
      cfg_wr_data = d_list[k];
      tick();
      cfg_wr_en = 1'b0;
      sample();
      n_checks++;
      if ({mem_req, mem_wr_en, mem_addr, mem_wr_strb, mem_wr_data} !==
          {1'b1, 1'b1, a_list[k][16:3], (a_list[k][2] ? 8'hF0 : 8'h0F), d_list[k], d_list[k]}) begin
        n_fail++;
        $display("FAIL write_issue_%0d: got req=%b wr_en=%b addr=%h strb=%h data=%h want 1 1 %h %h %h%h", k,
                 mem_req, mem_wr_en, mem_addr, mem_wr_strb, mem_wr_data, a_list[k][16:3],
                 (a_list[k][2] ? 8'hF0 : 8'h0F), d_list[k], d_list[k]);
      end
      ref_mem[a_list[k][16:2]] = d_list[k];
      tick();
      sample();
      n_checks++;
      if (mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL write_done_idle_%0d: got req=%b want 0", k, mem_req);
      end
      tick();
    end
    // Strobes must leave the other half of each word untouched.
    do_read(17'h00014, 20, cyc, d);
    n_checks++;
    if (cyc !== 4 || d !== ref_mem[15'h5]) begin
      n_fail++;
      $display("FAIL write_half_preserved: got cycle=%0d data=%h want 4 %h", cyc, d, ref_mem[15'h5]);
    end
    tick();
    do_read(17'h0001C, 20, cyc, d);
    n_checks++;
    if (cyc !== 4 || d !== ref_mem[15'h7]) begin
      n_fail++;
      $display("FAIL write_upper_readback: got cycle=%0d data=%h want 4 %h", cyc, d, ref_mem[15'h7]);
    end
    tick();
  endtask

  task automatic test_stall();
    mem_gnt = 1'b0;
    cfg_rd_en = 1'b1;
    cfg_rd_addr = 17'h00014;
    for (int c = 1; c <= 12; c++) begin
      tick();
      cfg_rd_en = 1'b0;
      if (c == 6) mem_gnt = 1'b1;
      sample();
      if (c <= 6) begin
        n_checks++;
        if ({mem_req, mem_wr_en, mem_addr} !== {1'b1, 1'b0, 14'h2}) begin
          n_fail++;
          $display("FAIL stall_req_stable: cycle %0d got req=%b wr_en=%b addr=%h want 1 0 0002", c, mem_req, mem_wr_en, mem_addr);
        end
      end
      n_checks++;
      if (cfg_rd_data_valid !== (c == 9)) begin
        n_fail++;
        $display("FAIL stall_valid_timing: cycle %0d got valid=%b want %b", c, cfg_rd_data_valid, (c == 9));
      end
      if (c == 9) begin
        n_checks++;
        if (cfg_rd_data !== ref_mem[15'h5]) begin
          n_fail++;
          $display("FAIL stall_data: got %h want %h", cfg_rd_data, ref_mem[15'h5]);
        end
      end
    end
    tick();
  endtask

  task automatic test_wr_rd_same();
    logic [16:0] a;
    logic [31:0] d;
    logic [31:0] got;
    int cyc;
    a = 17'({$urandom_range(64, 127), 2'b00});
    d = $urandom;
    mem_gnt = 1'b1;
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    cfg_rd_en = 1'b1; cfg_rd_addr = a;
    ref_mem[a[16:2]] = d;
    cyc = -1;
    got = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      cfg_wr_en = 1'b0;
      cfg_rd_en = 1'b0;
      sample();
      if (c == 1 || c == 2) begin
        n_checks++;
        if ({mem_req, mem_wr_en} !== {1'b1, (c == 1)}) begin
          n_fail++;
          $display("FAIL wr_rd_order: cycle %0d got req=%b wr_en=%b want 1 %b", c, mem_req, mem_wr_en, (c == 1));
        end
      end
      if (cfg_rd_data_valid === 1'b1) begin
        cyc = c;
        got = cfg_rd_data;
        break;
      end
    end
    n_checks++;
    if (cyc !== 5 || got !== ref_mem[a[16:2]]) begin
      n_fail++;
      $display("FAIL wr_rd_readback: got cycle=%0d data=%h want 5 %h", cyc, got, ref_mem[a[16:2]]);
    end
    tick();
  endtask

  task automatic test_overflow();
    int v0;
    logic [31:0] got;
    sample();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_err_clear: got %b want 0", cfg_err);
    end
    tick();
    v0 = valid_count;
    mem_gnt = 1'b0;
    cfg_rd_en = 1'b1; cfg_rd_addr = 17'h00010;
    tick();
    cfg_rd_addr = 17'h00014;
    tick();
    cfg_rd_en = 1'b0;
    sample();
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_err_set: got %b want 1", cfg_err);
    end
    tick();
    mem_gnt = 1'b1;
    got = '0;
    for (int c = 0; c < 15; c++) begin
      sample();
      if (cfg_rd_data_valid === 1'b1) got = cfg_rd_data;
      tick();
    end
    n_checks++;
    if (valid_count - v0 !== 1 || got !== ref_mem[15'h4]) begin
      n_fail++;
      $display("FAIL overflow_single_return: got pulses=%0d data=%h want 1 %h", valid_count - v0, got, ref_mem[15'h4]);
    end
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_err_sticky: got %b want 1", cfg_err);
    end
  endtask

  task automatic test_accept_on_issue();
    int v0;
    int second;
    do_reset();
    v0 = valid_count;
    mem_gnt = 1'b1;
    second = -1;
    cfg_rd_en = 1'b1; cfg_rd_addr = 17'h00010;
    tick();
    cfg_rd_addr = 17'h00014;
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) tick();
      if (c == 2) cfg_rd_en = 1'b0;
      sample();
      if (cfg_rd_data_valid === 1'b1 && c > 4) second = c;
    end
    tick();
    n_checks++;
    if (valid_count - v0 !== 2 || second !== 8 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_on_issue: got pulses=%0d second_cycle=%0d err=%b want 2 8 0", valid_count - v0, second, cfg_err);
    end
  endtask

  task automatic test_reset_mid_read();
    int v0;
    int cyc;
    logic [31:0] d;
    mem_gnt = 1'b1;
    cfg_rd_en = 1'b1; cfg_rd_addr = 17'h00014;
    tick();
    cfg_rd_en = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cfg_rd_data, cfg_rd_data_valid, cfg_err, mem_req, mem_wr_en, mem_addr, mem_wr_data, mem_wr_strb} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_read_outputs: got rd_data=%h valid=%b err=%b req=%b want all zero",
               cfg_rd_data, cfg_rd_data_valid, cfg_err, mem_req);
    end
    tick();
    tick();
    reset = 1'b0;
    v0 = valid_count;
    for (int c = 0; c < 8; c++) tick();
    n_checks++;
    if (valid_count - v0 !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_read_discard: got pulses=%0d want 0", valid_count - v0);
    end
    do_read(17'h00014, 20, cyc, d);
    n_checks++;
    if (cyc !== 4 || d !== ref_mem[15'h5]) begin
      n_fail++;
      $display("FAIL reset_mid_read_recover: got cycle=%0d data=%h want 4 %h", cyc, d, ref_mem[15'h5]);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int op;
      logic [16:0] wa, ra;
      logic [31:0] wd, exp_rd;
      logic need_wr, need_rd, done;
      op = $urandom_range(0, 2);
      wa = 17'({$urandom_range(64, 127), 2'b00});
      ra = (op == 2 && $urandom_range(0, 1) == 1) ? wa : 17'({$urandom_range(64, 127), 2'b00});
      wd = $urandom;
      need_wr = (op != 1);
      need_rd = (op != 0);
      if (need_wr) ref_mem[wa[16:2]] = wd;
      exp_rd = ref_mem[ra[16:2]];
      cfg_wr_en = need_wr; cfg_wr_addr = wa; cfg_wr_data = wd;
      cfg_rd_en = need_rd; cfg_rd_addr = ra;
      mem_gnt = ($urandom_range(0, 3) != 0);
      done = 1'b0;
      for (int c = 1; c <= 60 && !done; c++) begin
        tick();
        cfg_wr_en = 1'b0;
        cfg_rd_en = 1'b0;
        mem_gnt = ($urandom_range(0, 3) != 0);
        sample();
        if (need_wr && mem_req && mem_gnt && mem_wr_en) begin
          need_wr = 1'b0;
          n_checks++;
          if ({mem_addr, mem_wr_strb, mem_wr_data} !== {wa[16:3], (wa[2] ? 8'hF0 : 8'h0F), wd, wd}) begin
            n_fail++;
            $display("FAIL random_write_%0d: got addr=%h strb=%h data=%h want %h %h %h", it,
                     mem_addr, mem_wr_strb, mem_wr_data, wa[16:3], (wa[2] ? 8'hF0 : 8'h0F), {wd, wd});
          end
        end
        if (need_rd && cfg_rd_data_valid === 1'b1) begin
          need_rd = 1'b0;
          n_checks++;
          if (cfg_rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL random_read_%0d: addr=%h got %h want %h", it, ra, cfg_rd_data, exp_rd);
          end
        end
        done = !need_wr && !need_rd;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_timeout_%0d: got pending wr=%b rd=%b want none", it, need_wr, need_rd);
      end
      tick();
    end
    sample();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL random_no_err: got %b want 0", cfg_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_rd_en = 1'b0; cfg_rd_addr = '0;
    mem_gnt = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 32768; i++) ref_mem[i] = '0;
    test_reset();
    test_read_basic();
    test_write();
    test_stall();
    test_wr_rd_same();
    test_overflow();
    test_accept_on_issue();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/glb_bank_sram_cfg_ctrl.md
Name: glb_bank_sram_cfg_ctrl

Overview:
Per-bank configuration port controller that consumes the bank-steered SRAM config requests produced by the tile-level SRAM config controller. Converts 32-bit config-word writes and reads at byte addresses into 64-bit bank SRAM accesses with byte strobes. Arbitrates for the shared bank port, on which the data path has priority. Returns read data with a one-cycle `rd_data_valid` pulse.

Parameters:
BANK_ADDR_WIDTH, 17, byte address width within one bank
CGRA_CFG_DATA_WIDTH, 32, config data width
BANK_DATA_WIDTH, 64, SRAM word width
SRAM_LATENCY, 2, cycles from granted read to valid `mem_rd_data`

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cfg_wr_en  in  1  write request pulse
cfg_wr_addr  in  BANK_ADDR_WIDTH  write byte address
cfg_wr_data  in  CGRA_CFG_DATA_WIDTH  write data
cfg_rd_en  in  1  read request pulse
cfg_rd_addr  in  BANK_ADDR_WIDTH  read byte address
cfg_rd_data  out  CGRA_CFG_DATA_WIDTH  read data
cfg_rd_data_valid  out  1  one-cycle read-return pulse
cfg_err  out  1  sticky overflow flag
mem_req  out  1  bank port request
mem_gnt  in  1  bank port grant, same cycle as `mem_req`
mem_wr_en  out  1  1 = write, 0 = read
mem_addr  out  BANK_ADDR_WIDTH-3  64-bit word address (byte addr >> 3)
mem_wr_data  out  BANK_DATA_WIDTH  write data
mem_wr_strb  out  BANK_DATA_WIDTH/8  byte enables
mem_rd_data  in  BANK_DATA_WIDTH  SRAM read data, valid SRAM_LATENCY cycles after granted read

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; holding registers are invalidated.
- Capture:
  - A one-entry write holding register (`wr_pend`) and a one-entry read holding register (`rd_pend`) capture requests on the edge where `cfg_*_en` = 1.
  - Addr[1:0] is ignored. Addr[2] selects the half: 0 = bits[31:0], 1 = bits[63:32].
- Overflow:
  - `cfg_wr_en` while `wr_pend`=1 (or `cfg_rd_en` while `rd_pend`=1): new request is dropped, `cfg_err` sets to 1, and it stays set until reset.
  - A request arriving in the same cycle its entry issues (grant) is accepted, not dropped.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
  - IDLE: if `wr_pend` -> WR_ISSUE; else if `rd_pend` -> RD_ISSUE. Write has priority when both are pending.
  - WR_ISSUE:
    - Outputs: `mem_req`=1, `mem_wr_en`=1, `mem_wr_data` = {data, data}, `mem_wr_strb` = 8'hF0 if addr[2] else 8'h0F.
    - Holds until `mem_gnt`. On grant: clear `wr_pend`; -> RD_ISSUE if `rd_pend`, else IDLE.
  - RD_ISSUE:
    - Outputs: `mem_req`=1, `mem_wr_en`=0; all-zero strobes.
    - Holds until `mem_gnt`. On grant: clear `rd_pend`, latch addr[2] into `half_sel`, load counter with SRAM_LATENCY; -> RD_WAIT.
  - RD_WAIT:
    - Counter decrements each cycle. When counter reaches 0, `mem_rd_data` is sampled.
    - `cfg_rd_data` is registered with the selected half; `cfg_rd_data_valid` = 1 for exactly the next cycle; -> IDLE.
    - No bank issue while in RD_WAIT: at most one outstanding read. Writes may still be captured.
- Latency:
  - Read with immediate grant, `cfg_rd_en` in cycle 0: request in cycle 1, `mem_rd_data` in cycle 1+SRAM_LATENCY, `cfg_rd_data_valid` in cycle 2+SRAM_LATENCY (cycle 4 at default).
  - Write with immediate grant: written in cycle 1.
- `cfg_rd_data` holds its last value between pulses.
- `mem_req` deasserted mid-wait: illegal; `mem_addr`/`mem_wr_data` stay stable while `mem_req` is high and ungranted.
- Reset mid-read: in-flight return is discarded; no `cfg_rd_data_valid` is generated afterward.

Decomposition:
- Shared package `global_buffer_param`: BANK_ADDR_WIDTH, BANK_DATA_WIDTH, CGRA_CFG_DATA_WIDTH, SRAM_LATENCY.
- Shared package `global_buffer_pkg`: enum `sram_cfg_state_t`.
- No sub-module; half-select/strobe generation stays inline.

Test Plan:
- Write addr 0x00010, data 0xDEADBEEF, `mem_gnt` tied 1 -> cycle 1: `mem_addr`=0x2, `mem_wr_strb`=0x0F, `mem_wr_data`=0xDEADBEEF_DEADBEEF.
- Read addr 0x00014, SRAM returns 0x12345678_9ABCDEF0 -> `cfg_rd_data`=0x12345678, `cfg_rd_data_valid` single pulse in cycle 4.
- `mem_gnt` held 0 for 5 cycles during a read -> `mem_req` and `mem_addr` stable; valid arrives 5 cycles later than the baseline.
- `cfg_wr_en` and `cfg_rd_en` in the same cycle -> write issued first, read next; returned read data reflects the just-written word.
- Second `cfg_rd_en` while the first read is pending and ungranted -> `cfg_err`=1, only one `cfg_rd_data_valid` pulse.
- Assert reset during RD_WAIT -> all outputs 0, no valid pulse afterward; a new read after reset completes normally.
